// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared glyph constants, FSM state type and value width for
//                the signed 7-seg capture decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int VAL_W = 5;

    // Active-low a-g glyphs, bit 0 = segment a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        EMIT   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph_decode
//  Description : Combinational active-low glyph to magnitude decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_decode import seg7_pkg::*; #(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [6:0] seg_n_i,
    output logic [3:0] mag_o,
    output logic       illegal_o,
    output logic       blank_o
);

    logic w_hex;

    always_comb begin
        mag_o     = 4'd0;
        illegal_o = 1'b0;
        blank_o   = 1'b0;
        w_hex     = 1'b0;
        case (seg_n_i)
            SEG_0:     mag_o = 4'd0;
            SEG_1:     mag_o = 4'd1;
            SEG_2:     mag_o = 4'd2;
            SEG_3:     mag_o = 4'd3;
            SEG_4:     mag_o = 4'd4;
            SEG_5:     mag_o = 4'd5;
            SEG_6:     mag_o = 4'd6;
            SEG_7:     mag_o = 4'd7;
            SEG_8:     mag_o = 4'd8;
            SEG_9:     mag_o = 4'd9;
            SEG_A:     begin mag_o = 4'd10; w_hex = 1'b1; end
            SEG_B:     begin mag_o = 4'd11; w_hex = 1'b1; end
            SEG_C:     begin mag_o = 4'd12; w_hex = 1'b1; end
            SEG_D:     begin mag_o = 4'd13; w_hex = 1'b1; end
            SEG_E:     begin mag_o = 4'd14; w_hex = 1'b1; end
            SEG_F:     begin mag_o = 4'd15; w_hex = 1'b1; end
            SEG_BLANK: blank_o = 1'b1;
            default:   illegal_o = 1'b1;
        endcase
        // Decimal-only builds treat letter glyphs as garbage on the bus
        if (w_hex && !HEX_EN) begin
            illegal_o = 1'b1;
            mag_o     = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_capture_decoder
//  Description : Recovers the signed value shown on an active-low 7-seg bus,
//                debounced, duplicate-suppressed, delivered over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture_decoder import seg7_pkg::*; #(
    parameter int STABLE_CYCLES = 4,
    parameter bit HEX_EN        = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_n,
    input  logic             neg_n,
    output logic [VAL_W-1:0] out_value,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [7:0] c_stable    = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_blank_pat = {1'b1, SEG_BLANK};

    logic [7:0]       samp_q, held_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       pend_q, pend_d, last_q, last_d;
    logic             last_vld_q, last_vld_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;
    logic [VAL_W-1:0] value_q, value_d;
    state_t           state_q, state_d;

    logic             w_match, w_qual, w_accept, w_dup, w_fresh;
    logic             w_illegal, w_blank;
    logic [3:0]       w_mag;
    logic [VAL_W-1:0] w_value;

    seg7_glyph_decode #(.HEX_EN(HEX_EN)) u_decode (
        .seg_n_i   (samp_q[6:0]),
        .mag_o     (w_mag),
        .illegal_o (w_illegal),
        .blank_o   (w_blank)
    );

    // Run-length filter: qualifies exactly once when the run reaches c_stable
    always_comb begin
        w_match = (samp_q == held_q);
        cnt_d   = 8'd1;
        w_qual  = (c_stable == 8'd1);
        if (w_match) begin
            cnt_d  = (cnt_q == c_stable) ? cnt_q : cnt_q + 8'd1;
            w_qual = (cnt_q == c_stable - 8'd1);
        end
    end

    always_comb begin
        w_value    = samp_q[7] ? {1'b0, w_mag} : -{1'b0, w_mag};
        w_accept   = (state_q == EMIT) && out_ready;
        // While a value is pending it becomes the last-emitted one on accept
        w_dup      = (state_q == EMIT) ? (samp_q == pend_q)
                                       : (last_vld_q && (samp_q == last_q));
        w_fresh    = w_qual && !w_blank && !w_dup;

        state_d    = state_q;
        value_d    = value_q;
        err_d      = err_q;
        pend_d     = pend_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        overrun_d  = overrun_q;

        if (w_accept) begin
            last_d     = pend_q;
            last_vld_d = 1'b1;
            state_d    = SETTLE;
        end
        if (w_qual && w_blank) begin
            last_vld_d = 1'b0;
        end
        if (w_fresh) begin
            if ((state_q == SETTLE) || w_accept) begin
                state_d = EMIT;
                value_d = w_illegal ? '0 : w_value;
                err_d   = w_illegal;
                pend_d  = samp_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q     <= c_blank_pat;
            held_q     <= c_blank_pat;
            cnt_q      <= 8'd0;
            pend_q     <= 8'd0;
            last_q     <= 8'd0;
            last_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            value_q    <= '0;
            state_q    <= SETTLE;
        end else begin
            samp_q     <= {neg_n, seg_n};
            held_q     <= samp_q;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            value_q    <= value_d;
            state_q    <= state_d;
        end
    end

    assign out_value = value_q;
    assign out_err   = err_q;
    assign out_valid = (state_q == EMIT);
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_capture_decoder
//  Description : Directed and randomized checks of seg7_capture_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_capture_decoder;

    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_n = 7'h24;
    logic       neg_n = 1'b1;
    logic       out_ready = 1'b1;
    logic [4:0] out_value, d2_value;
    logic       out_err, out_valid, overrun, d2_err, d2_valid, d2_overrun;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic       m_valid = 1'b0, m_err = 1'b0, m_over = 1'b0, m_lastv = 1'b0;
    logic [4:0] m_val = 5'd0;
    logic [7:0] m_pend = 8'd0, m_last = 8'd0, prev_cap = 8'hFF;
    logic [7:0] hist [$];

    // handshakes observed on the main DUT
    int         acc_cnt = 0;
    logic [4:0] acc_last = 5'd0;
    logic       acc_err = 1'b0;

    always #5 clk = ~clk;

    seg7_capture_decoder #(.STABLE_CYCLES(S), .HEX_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .seg_n(seg_n), .neg_n(neg_n),
        .out_value(out_value), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    seg7_capture_decoder #(.STABLE_CYCLES(S), .HEX_EN(1'b0)) dut_dec (
        .clk(clk), .reset(reset), .seg_n(seg_n), .neg_n(neg_n),
        .out_value(d2_value), .out_err(d2_err), .out_valid(d2_valid),
        .out_ready(out_ready), .overrun(d2_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [7:0] pat, input bit hexen,
                                       output logic [4:0] val, output logic err, output logic blk);
        int mag;
        mag = -1;
        blk = (pat[6:0] == 7'h7F);
        for (int i = 0; i < 16; i++)
            if (GLYPH[i] == pat[6:0] && (i < 10 || hexen)) mag = i;
        err = !blk && (mag < 0);
        if (err || blk)  val = 5'd0;
        else if (!pat[7]) val = 5'(-mag);
        else              val = 5'(mag);
    endfunction

    // One clock edge of the specified behaviour: a sample qualifies when the
    // most recent run of identical samples has just reached length S.
    task automatic model_step();
        logic [7:0] e;
        logic       q, acc, dup, fresh, blk, err;
        logic [4:0] val;
        int         n;
        if (reset) begin
            m_valid = 1'b0; m_err = 1'b0; m_over = 1'b0; m_lastv = 1'b0;
            m_val = 5'd0; m_pend = 8'd0; m_last = 8'd0;
            prev_cap = 8'hFF;
            hist.delete();
            return;
        end
        e = prev_cap;
        prev_cap = {neg_n, seg_n};
        hist.push_back(e);
        if (hist.size() > S + 1) void'(hist.pop_front());
        n = int'(hist.size());
        q = (n >= S);
        if (q) begin
            for (int i = n - S; i < n; i++) if (hist[i] != e) q = 1'b0;
            if (n == S + 1 && hist[0] == e) q = 1'b0;
        end
        ref_decode(e, 1'b1, val, err, blk);
        acc   = m_valid && out_ready;
        dup   = m_valid ? (e == m_pend) : (m_lastv && e == m_last);
        fresh = q && !blk && !dup;
        if (acc) begin m_last = m_pend; m_lastv = 1'b1; end
        if (q && blk) m_lastv = 1'b0;
        if (fresh && m_valid && !acc) m_over = 1'b1;
        else if (fresh) begin
            m_valid = 1'b1; m_pend = e; m_val = val; m_err = err;
        end else if (acc) m_valid = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        if (!reset && out_valid && out_ready) begin
            acc_cnt++;
            acc_last = out_value;
            acc_err  = out_err;
        end
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("valid",   {31'd0, out_valid}, {31'd0, m_valid});
            check("value",   {27'd0, out_value}, {27'd0, m_val});
            check("err",     {31'd0, out_err},   {31'd0, m_err});
            check("overrun", {31'd0, overrun},   {31'd0, m_over});
        end
    end

    task automatic hold(input logic [6:0] s, input logic n, input int cyc);
        seg_n = s;
        neg_n = n;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        int a0;
        logic [6:0] pat;
        logic       nn;
        int         r, len;

        // 1: latency and single emission of +2
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (S) @(negedge clk);
        check("t1_lat_lo", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_lat_hi", {31'd0, out_valid}, 32'd1);
        check("t1_val", {27'd0, out_value}, 32'd2);
        repeat (15) @(negedge clk);
        check("t1_once", acc_cnt, 32'd1);

        // 2: negative values
        hold(7'h19, 1'b0, 10);
        check("t2_m4", {27'd0, acc_last}, {27'd0, 5'b11100});
        hold(7'h0E, 1'b0, 10);
        check("t2_m15", {27'd0, acc_last}, {27'd0, 5'b10001});

        // 3: short glitch never emitted
        a0 = acc_cnt;
        hold(7'h79, 1'b1, S - 1);
        hold(7'h40, 1'b1, 10);
        check("t3_cnt", acc_cnt - a0, 32'd1);
        check("t3_val", {27'd0, acc_last}, 32'd0);

        // 4: stall and overrun
        out_ready = 1'b0;
        hold(7'h30, 1'b1, 8);
        check("t4_v3", {27'd0, out_value}, 32'd3);
        hold(7'h78, 1'b1, 8);
        check("t4_hold3", {27'd0, out_value}, 32'd3);
        check("t4_ovr", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_acc3", {27'd0, acc_last}, 32'd3);
        check("t4_no7", {31'd0, out_valid}, 32'd0);
        check("t4_sticky", {31'd0, overrun}, 32'd1);

        // 5: blank re-arms duplicates, illegal pattern, decimal-only build
        out_ready = 1'b1;
        a0 = acc_cnt;
        hold(7'h7F, 1'b1, 8);
        hold(7'h12, 1'b1, 8);
        hold(7'h7F, 1'b1, 8);
        hold(7'h12, 1'b1, 8);
        check("t5_two", acc_cnt - a0, 32'd2);
        check("t5_val5", {27'd0, acc_last}, 32'd5);
        hold(7'h55, 1'b1, 8);
        check("t5_err", {31'd0, acc_err}, 32'd1);
        check("t5_err_val", {27'd0, acc_last}, 32'd0);
        out_ready = 1'b0;
        hold(7'h08, 1'b1, 8);
        check("t5_hexA", {27'd0, out_value}, 32'd10);
        check("t5_hexA_err", {31'd0, out_err}, 32'd0);
        check("t5_dec_valid", {31'd0, d2_valid}, 32'd1);
        check("t5_dec_err", {31'd0, d2_err}, 32'd1);
        check("t5_dec_val", {27'd0, d2_value}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // 6: reset mid-handshake
        out_ready = 1'b0;
        hold(7'h24, 1'b1, 8);
        check("t6_pend", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_value", {27'd0, out_value}, 32'd0);
        check("t6_rst_err", {31'd0, out_err}, 32'd0);
        check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        repeat (S) @(negedge clk);
        check("t6_relat_lo", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t6_reemit", {31'd0, out_valid}, 32'd1);
        check("t6_reval", {27'd0, out_value}, 32'd2);

        // randomized segments with random ready and rare resets
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       pat = GLYPH[$urandom_range(0, 15)];
            else if (r == 7) pat = 7'h7F;
            else             pat = 7'($urandom);
            nn  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                seg_n     = pat;
                neg_n     = nn;
                out_ready = ($urandom_range(0, 3) != 0);
                reset     = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
